cfo_calc_multi: RTL
===================

Name: cfo_calc_multi

Overview:
- Parametrised successor to the single-channel CFO estimator.
- Takes correlator peak pairs C0/C1 from up to NUM_CH time-multiplexed PSS/SSS streams and forms angle(C0·conj(C1)) with an iterative CORDIC vectoring atan2. The LUT and divider are gone.
- Optionally averages 2^AVG_LOG2 estimates per channel before emitting a normalised CFO.
- Sits between the PSS correlators and the NCO/CFO-correction stage.

Parameters:
- C_DW, 32: packed complex input width; {im, re}, each C_DW/2 signed, im in the upper half.
- CFO_DW, 20: output angle width. Two's complement; -2^(CFO_DW-1) = -pi; modular, so +pi wraps to -pi.
- CORDIC_ITER, 18: vectoring iterations, range 8..CFO_DW.
- NUM_CH, 1: number of channels, 1..16.
- AVG_LOG2, 0: log2 of estimates averaged per channel, 0..6.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous, active-low reset.
- C0_i  in  C_DW  first correlation value.
- C1_i  in  C_DW  second correlation value.
- ch_i  in  CH_W = max(1, clog2(NUM_CH))  channel tag of the sample.
- valid_i  in  1  input valid.
- ready_o  out  1  block can accept a sample.
- clear_i  in  1  synchronous clear of all accumulators and counters.
- CFO_norm_o  out  CFO_DW  averaged normalised CFO angle.
- ch_o  out  CH_W  channel tag of CFO_norm_o.
- valid_o  out  1  one-cycle output strobe.
- err_o  out  1  one-cycle strobe: sample arrived with ch_i >= NUM_CH.

Behaviour:
- Reset (async, reset_ni=0): state IDLE; ready_o=1; valid_o=0; err_o=0; CFO_norm_o=0; ch_o=0; all accumulators and counters = 0. Reset mid-operation aborts the estimate; no valid_o follows.
- Handshake:
  - Sample accepted when valid_i && ready_o; C0, C1 and ch are captured.
  - ready_o=1 only in IDLE. valid_i while busy is ignored, never queued.
  - No output backpressure; valid_o is a pulse.
- FSM: IDLE -> MULT -> PREROT -> ITER (CORDIC_ITER cycles) -> ACCUM -> IDLE.
  - MULT:
    - re = C0re·C1re + C0im·C1im; im = C0im·C1re − C0re·C1im.
    - Full precision: C_DW+1 bits each; no truncation.
  - PREROT:
    - x = re, y = im, z = 0.
    - If re < 0: x = −re, y = −im, z = (im >= 0) ? +pi : −pi.
    - Negation is widened by 1 bit so −min cannot overflow.
  - ITER, step i = 0..CORDIC_ITER−1:
    - If y >= 0: x += y>>>i, y −= x>>>i, z += atan(2^-i).
    - Else: x −= y>>>i, y += x>>>i, z −= atan(2^-i).
    - Uses old x/y values (simultaneous update).
    - x/y width C_DW+3; z width CFO_DW+2 with 2 guard LSBs.
    - atan constants are rounded-to-nearest parameters computed at elaboration.
  - ACCUM:
    - angle = z rounded to CFO_DW (add half LSB, drop guards).
    - If re = im = 0: angle forced to 0.
    - acc[ch] (CFO_DW+AVG_LOG2 signed) += sign-extended angle; cnt[ch]++.
    - When cnt[ch] reaches 2^AVG_LOG2: CFO_norm_o = acc[ch] >>> AVG_LOG2 (arithmetic, floor), ch_o = ch, valid_o=1 next cycle; acc[ch], cnt[ch] cleared.
    - AVG_LOG2=0: every estimate is output.
- Latency and throughput:
  - valid_o is high exactly CORDIC_ITER+4 cycles after the handshake cycle.
  - ready_o returns to 1 in the cycle after ACCUM; throughput is one sample per CORDIC_ITER+4 cycles.
- Invalid channel: ch_i >= NUM_CH is accepted and err_o pulses one cycle after the handshake. The sample is dropped (return to IDLE, no accumulation, no valid_o).
- clear_i:
  - Clears all acc/cnt in the same cycle.
  - Asserted during ACCUM, the in-flight estimate is discarded: no valid_o.
  - An in-flight estimate in MULT/PREROT/ITER continues and accumulates into the cleared registers.
  - clear_i with a handshake in IDLE: the sample is still accepted.
- Accuracy: |error| <= 4 LSB vs. the ideal atan2 for CORDIC_ITER >= CFO_DW−2 and max(|re|,|im|) >= 2^10.
- Averaging is arithmetic on wrapped angles. Sets straddling ±pi are not unwrapped; this is a known limitation and upstream keeps |CFO| < pi/2 when AVG_LOG2 > 0.

Test Plan:
- Reset: hold reset_ni=0 with random inputs -> ready_o=1, valid_o=0, CFO_norm_o=0. Release, then C0=(re 0, im 16384), C1=(16384, 0) -> valid_o exactly 22 cycles later (default ITER 18), CFO_norm_o = 262144 ±4 (pi/2).
- Quadrants: C0=(−16384,0), C1=(16384,0) -> ±524288 (−pi, wrap accepted within 4 LSB). C0=(11585,−11585), C1=(16384,0) -> −131072 ±4. Sweep 360 angles at 1° -> all within ±4 LSB.
- Zero/extremes: C0=0 -> CFO_norm_o=0. C0=C1=(−32768,−32768) -> 0 ±4, no overflow.
- Averaging, NUM_CH=2, AVG_LOG2=2: interleave ch0 angles {+1000,+1002,+998,+1004} LSB and ch1 {−2000 ×4} -> exactly two valid_o, on the 4th sample of each channel. ch_o=0 gives 1001 ±4; ch_o=1 gives −2000 ±4.
- Handshake: hold valid_i=1 continuously -> ready_o low for CORDIC_ITER+3 cycles after each accept, one accept per CORDIC_ITER+4 cycles. Send ch_i=3 with NUM_CH=2 -> err_o pulse, no valid_o.
- Reset/clear mid-op: assert reset_ni=0 during ITER -> no valid_o, acc cleared. Assert clear_i in the ACCUM cycle of the 4th averaged sample -> no valid_o; the next 4 samples produce a fresh average.

Source files
------------

// File: rtl/cfo_calc_multi.sv
// Multi-channel CFO estimator: forms angle(C0*conj(C1)) with an iterative
// CORDIC vectoring atan2 and averages 2^AVG_LOG2 estimates per channel.
module cfo_calc_multi #(
    parameter int unsigned C_DW        = 32,
    parameter int unsigned CFO_DW      = 20,
    parameter int unsigned CORDIC_ITER = 18,
    parameter int unsigned NUM_CH      = 1,
    parameter int unsigned AVG_LOG2    = 0,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [C_DW-1:0]   C0_i,
    input  logic [C_DW-1:0]   C1_i,
    input  logic [CH_W-1:0]   ch_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              clear_i,
    output logic [CFO_DW-1:0] CFO_norm_o,
    output logic [CH_W-1:0]   ch_o,
    output logic              valid_o,
    output logic              err_o
);

    localparam int unsigned HW    = C_DW / 2;           // one complex component
    localparam int unsigned PW    = C_DW + 1;           // full-precision re/im
    localparam int unsigned XW    = C_DW + 3;           // CORDIC x/y
    localparam int unsigned ZW    = CFO_DW + 2;         // CORDIC z, 2 guard LSBs
    localparam int unsigned AW    = CFO_DW + AVG_LOG2;  // per-channel accumulator
    localparam int unsigned CNT_W = AVG_LOG2 + 1;
    localparam int unsigned IW    = $clog2(CORDIC_ITER);
    localparam int unsigned NSLOT = 1 << CH_W;

    // +pi and -pi share one encoding in the modular z register
    localparam logic [ZW-1:0] Z_PI = {1'b1, {(ZW-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MULT   = 3'd1,
        S_PREROT = 3'd2,
        S_ITER   = 3'd3,
        S_ACCUM  = 3'd4
    } state_t;

    // atan(2^-i) in z LSBs (pi = 2^(ZW-1)), rounded to nearest
    function automatic logic [ZW-1:0] atan_lsb(input int unsigned i);
        real a;
        a = $atan(1.0 / (2.0 ** i)) * (2.0 ** (ZW - 1)) / 3.14159265358979323846;
        return ZW'($rtoi(a + 0.5));
    endfunction

    state_t                   r_state;
    logic                     r_ready;
    logic                     r_valid;
    logic                     r_err;
    logic [CFO_DW-1:0]        r_cfo;
    logic [CH_W-1:0]          r_ch_o;
    logic [C_DW-1:0]          r_c0;
    logic [C_DW-1:0]          r_c1;
    logic [CH_W-1:0]          r_ch;
    logic signed [PW-1:0]     r_re;
    logic signed [PW-1:0]     r_im;
    logic                     r_zero;
    logic signed [XW-1:0]     r_x;
    logic signed [XW-1:0]     r_y;
    logic [ZW-1:0]            r_z;
    logic [IW-1:0]            r_iter;
    logic signed [AW-1:0]     r_acc [NSLOT];
    logic [CNT_W-1:0]         r_cnt [NSLOT];

    logic [ZW-1:0]            w_atan [CORDIC_ITER];
    logic signed [HW-1:0]     w_c0_re, w_c0_im, w_c1_re, w_c1_im;
    logic signed [C_DW-1:0]   w_p_rr, w_p_ii, w_p_ir, w_p_ri;
    logic signed [PW-1:0]     w_re, w_im;
    logic signed [XW-1:0]     w_re_x, w_im_x;
    logic signed [XW-1:0]     w_xs, w_ys;
    logic signed [CFO_DW-1:0] w_angle;
    logic signed [AW-1:0]     w_acc_new;
    logic [CNT_W-1:0]         w_cnt_new;
    logic [CFO_DW-1:0]        w_avg;
    logic                     w_done;

    // arctangent table, one constant per iteration
    for (genvar gi = 0; gi < int'(CORDIC_ITER); gi++) begin : g_atan
        assign w_atan[gi] = atan_lsb(gi);
    end

    // complex multiply C0 * conj(C1) at full precision
    assign w_c0_re = r_c0[HW-1:0];
    assign w_c0_im = r_c0[C_DW-1:HW];
    assign w_c1_re = r_c1[HW-1:0];
    assign w_c1_im = r_c1[C_DW-1:HW];
    assign w_p_rr  = C_DW'(w_c0_re) * C_DW'(w_c1_re);
    assign w_p_ii  = C_DW'(w_c0_im) * C_DW'(w_c1_im);
    assign w_p_ir  = C_DW'(w_c0_im) * C_DW'(w_c1_re);
    assign w_p_ri  = C_DW'(w_c0_re) * C_DW'(w_c1_im);
    assign w_re    = PW'(w_p_rr) + PW'(w_p_ii);
    assign w_im    = PW'(w_p_ir) - PW'(w_p_ri);

    // widened operands so that negating the most negative value cannot overflow
    assign w_re_x  = XW'(r_re);
    assign w_im_x  = XW'(r_im);

    // CORDIC shifted terms for the current iteration
    assign w_xs    = r_x >>> r_iter;
    assign w_ys    = r_y >>> r_iter;

    // round z to the output width; a zero vector has no defined angle
    assign w_angle   = r_zero ? '0 : CFO_DW'((r_z + ZW'(2)) >> 2);
    assign w_acc_new = r_acc[r_ch] + AW'(w_angle);
    assign w_cnt_new = r_cnt[r_ch] + CNT_W'(1);
    assign w_done    = (w_cnt_new == CNT_W'(1 << AVG_LOG2));
    assign w_avg     = CFO_DW'(w_acc_new >>> AVG_LOG2);

    // control FSM, datapath registers and per-channel averaging
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cfo   <= '0;
            r_ch_o  <= '0;
            r_c0    <= '0;
            r_c1    <= '0;
            r_ch    <= '0;
            r_re    <= '0;
            r_im    <= '0;
            r_zero  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_iter  <= '0;
            for (int k = 0; k < int'(NSLOT); k++) begin
                r_acc[k] <= '0;
                r_cnt[k] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            if (clear_i) begin
                for (int k = 0; k < int'(NSLOT); k++) begin
                    r_acc[k] <= '0;
                    r_cnt[k] <= '0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        if (32'(ch_i) >= NUM_CH) begin
                            r_err <= 1'b1;
                        end else begin
                            r_c0    <= C0_i;
                            r_c1    <= C1_i;
                            r_ch    <= ch_i;
                            r_ready <= 1'b0;
                            r_state <= S_MULT;
                        end
                    end
                end

                S_MULT: begin
                    r_re    <= w_re;
                    r_im    <= w_im;
                    r_zero  <= (w_re == '0) && (w_im == '0);
                    r_state <= S_PREROT;
                end

                S_PREROT: begin
                    // fold left half-plane vectors into the right half-plane
                    if (r_re[PW-1]) begin
                        r_x <= -w_re_x;
                        r_y <= -w_im_x;
                        r_z <= Z_PI;
                    end else begin
                        r_x <= w_re_x;
                        r_y <= w_im_x;
                        r_z <= '0;
                    end
                    r_iter  <= '0;
                    r_state <= S_ITER;
                end

                S_ITER: begin
                    if (!r_y[XW-1]) begin
                        r_x <= r_x + w_ys;
                        r_y <= r_y - w_xs;
                        r_z <= r_z + w_atan[r_iter];
                    end else begin
                        r_x <= r_x - w_ys;
                        r_y <= r_y + w_xs;
                        r_z <= r_z - w_atan[r_iter];
                    end
                    if (r_iter == IW'(CORDIC_ITER - 1)) begin
                        r_state <= S_ACCUM;
                    end else begin
                        r_iter <= r_iter + IW'(1);
                    end
                end

                S_ACCUM: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    // a clear in this cycle discards the estimate
                    if (!clear_i) begin
                        if (w_done) begin
                            r_acc[r_ch] <= '0;
                            r_cnt[r_ch] <= '0;
                            r_cfo       <= w_avg;
                            r_ch_o      <= r_ch;
                            r_valid     <= 1'b1;
                        end else begin
                            r_acc[r_ch] <= w_acc_new;
                            r_cnt[r_ch] <= w_cnt_new;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign ready_o    = r_ready;
    assign valid_o    = r_valid;
    assign err_o      = r_err;
    assign CFO_norm_o = r_cfo;
    assign ch_o       = r_ch_o;

endmodule
